// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, instruction memory reads, prefetch FIFO and redirect flush
// for the 19-bit CPU front end.
module instr_fetch_unit #(
    parameter int WORD_SIZE = 19,
    parameter int ADDR_SIZE = 19,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           fetch_en,
    output logic                           imem_rd_en,
    output logic [ADDR_SIZE-1:0]           imem_addr,
    input  logic [WORD_SIZE-1:0]           imem_rdata,
    input  logic                           imem_rvalid,
    input  logic                           redirect,
    input  logic [ADDR_SIZE-1:0]           redirect_pc,
    output logic [WORD_SIZE-1:0]           instr,
    output logic [ADDR_SIZE-1:0]           instr_pc,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state;
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] inflight_pc;
    logic                 inflight;
    logic                 drop;
    logic [WORD_SIZE-1:0] word_mem [FIFO_DEPTH];
    logic [ADDR_SIZE-1:0] pc_mem [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;
    logic [CW:0]          used;
    logic                 issue;
    logic                 push;
    logic                 pop;

    // An outstanding read holds a FIFO credit so its response always has room.
    assign used  = {1'b0, count} + (CW+1)'(inflight);
    assign issue = state == RUN && fetch_en && !redirect && used < (CW+1)'(FIFO_DEPTH);
    assign push  = imem_rvalid && !drop && !redirect;
    assign pop   = instr_valid && instr_ready && !redirect;

    assign imem_rd_en  = issue;
    assign imem_addr   = issue ? pc : '0;
    assign instr_valid = count != '0;
    assign instr       = instr_valid ? word_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;
    assign fifo_count  = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state    <= redirect ? FLUSH : (fetch_en ? RUN : IDLE);
            inflight <= issue ? 1'b1 : (imem_rvalid ? 1'b0 : inflight);
            // A response still outstanding past a redirect belongs to the old stream.
            drop     <= redirect ? (inflight && !imem_rvalid) : (imem_rvalid ? 1'b0 : drop);
            if (issue)
                inflight_pc <= pc;
            if (redirect) begin
                pc     <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                pc     <= issue ? pc + ADDR_SIZE'(1) : pc;
                rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
                wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
                count  <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a 1-cycle memory model
// returning mem[a] = a + 0x100.
module tb_instr_fetch_unit;
    typedef struct packed {
        logic [18:0] pc;
        logic [18:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_rd_en;
    logic [18:0] imem_addr;
    logic [18:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect = 1'b0;
    logic [18:0] redirect_pc = '0;
    logic [18:0] instr;
    logic [18:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int issued = 0;
    exp_t exp_q[$];
    logic [18:0] exp_fetch = '0;
    logic        hold = 1'b0;
    logic [18:0] hold_instr;
    logic [18:0] hold_pc;

    instr_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= imem_rd_en;
            imem_rdata  <= imem_addr + 19'h100;
        end
    end

    // Monitor: checks issue addresses against the bench PC model, pushes expected
    // instructions, and pops/compares on every accepted handshake.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_fetch = '0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                if (instr !== hold_instr || instr_pc !== hold_pc) begin
                    errors++;
                    $display("FAIL stable: instr=%h pc=%h required instr=%h pc=%h", instr, instr_pc, hold_instr, hold_pc);
                end
            end
            if (redirect) begin
                checks++;
                if (imem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_during_redirect: rd_en=%b required 0", imem_rd_en);
                end
                exp_q.delete();
                exp_fetch = redirect_pc;
            end else begin
                if (instr_valid && instr_ready) begin
                    exp_t e;
                    accepted++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_instr: pc=%h instr=%h required none", instr_pc, instr);
                    end else begin
                        e = exp_q.pop_front();
                        if (instr_pc !== e.pc || instr !== e.w) begin
                            errors++;
                            $display("FAIL accept: pc=%h instr=%h required pc=%h instr=%h", instr_pc, instr, e.pc, e.w);
                        end
                    end
                end
                if (imem_rd_en) begin
                    checks++;
                    if (imem_addr !== exp_fetch) begin
                        errors++;
                        $display("FAIL issue_addr: addr=%h required %h", imem_addr, exp_fetch);
                    end
                    exp_q.push_back('{pc: exp_fetch, w: exp_fetch + 19'h100});
                    exp_fetch = exp_fetch + 19'd1;
                    issued++;
                end
            end
            hold = instr_valid && !instr_ready && !redirect;
            hold_instr = instr;
            hold_pc = instr_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic ready);
        reset_n = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        fetch_en = 1'b1;
        instr_ready = ready;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({imem_rd_en, imem_addr, instr, instr_pc, instr_valid, fifo_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b addr=%h instr=%h pc=%h v=%b cnt=%0d required all 0",
                     imem_rd_en, imem_addr, instr, instr_pc, instr_valid, fifo_count);
        end
    endtask

    task automatic test_first_fetch();
        int first_rd = -1;
        int first_v = -1;
        int a0;
        int i0;
        restart(1'b1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (imem_rd_en && first_rd < 0) first_rd = c;
            if (instr_valid && first_v < 0) begin
                first_v = c;
                checks++;
                if (instr_pc !== 19'h0 || instr !== 19'h100) begin
                    errors++;
                    $display("FAIL first_instr: pc=%h instr=%h required pc=00000 instr=00100", instr_pc, instr);
                end
            end
        end
        checks++;
        if (first_rd != 1 || first_v != 3) begin
            errors++;
            $display("FAIL latency: rd_cycle=%0d valid_cycle=%0d required 1 and 3", first_rd, first_v);
        end
        a0 = accepted;
        i0 = issued;
        repeat (8) tick();
        checks++;
        if (accepted - a0 != 8 || issued - i0 != 8) begin
            errors++;
            $display("FAIL throughput: accepted=%0d issued=%0d required 8 and 8", accepted - a0, issued - i0);
        end
    endtask

    task automatic test_backpressure();
        int i0;
        int a0;
        restart(1'b0);
        i0 = issued;
        repeat (10) tick();
        checks++;
        if (issued - i0 != 4 || fifo_count !== 3'd4 || imem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL fill: issued=%0d count=%0d rd=%b required 4, 4, 0", issued - i0, fifo_count, imem_rd_en);
        end
        a0 = accepted;
        instr_ready = 1'b1;
        tick();
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 19'd4) begin
            errors++;
            $display("FAIL resume: rd=%b addr=%h required 1 and 00004", imem_rd_en, imem_addr);
        end
        repeat (3) tick();
        checks++;
        if (accepted - a0 != 4) begin
            errors++;
            $display("FAIL drain: accepted=%0d required 4", accepted - a0);
        end
    endtask

    task automatic test_redirect_flush();
        int found = 0;
        restart(1'b0);
        repeat (5) tick();
        checks++;
        if (fifo_count !== 3'd3 || imem_rvalid !== 1'b1 || imem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL pre_flush: count=%0d rvalid=%b rd=%b required 3, 1, 0", fifo_count, imem_rvalid, imem_rd_en);
        end
        redirect = 1'b1;
        redirect_pc = 19'h00040;
        tick();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || fifo_count !== 3'd0 || imem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL flush: valid=%b count=%0d rd=%b required 0, 0, 0", instr_valid, fifo_count, imem_rd_en);
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 19'h00040) begin
            errors++;
            $display("FAIL refetch: rd=%b addr=%h required 1 and 00040", imem_rd_en, imem_addr);
        end
        for (int c = 0; c < 6 && found == 0; c++) begin
            tick();
            if (instr_valid) found = 1;
        end
        checks++;
        if (found == 0 || instr_pc !== 19'h00040) begin
            errors++;
            $display("FAIL redirect_head: found=%0d pc=%h required 1 and 00040", found, instr_pc);
        end
    endtask

    task automatic test_redirect_with_pop();
        int a0;
        int found = 0;
        repeat (3) tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stream_valid: valid=%b required 1", instr_valid);
        end
        a0 = accepted;
        redirect = 1'b1;
        redirect_pc = 19'h00200;
        tick();
        redirect = 1'b0;
        checks++;
        if (accepted != a0 || fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_vs_flush: accepted=%0d count=%0d valid=%b required 0, 0, 0", accepted - a0, fifo_count, instr_valid);
        end
        for (int c = 0; c < 6 && found == 0; c++) begin
            tick();
            if (instr_valid) found = 1;
        end
        checks++;
        if (found == 0 || instr_pc !== 19'h00200 || instr !== 19'h00300) begin
            errors++;
            $display("FAIL restart_head: found=%0d pc=%h instr=%h required 1, 00200, 00300", found, instr_pc, instr);
        end
    endtask

    task automatic test_pc_wrap();
        logic [18:0] tbl [4] = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
        redirect = 1'b1;
        redirect_pc = 19'h7FFFE;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (imem_rd_en !== 1'b1 || imem_addr !== tbl[i]) begin
                errors++;
                $display("FAIL wrap_%0d: rd=%b addr=%h required 1 and %h", i, imem_rd_en, imem_addr, tbl[i]);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_fetch_stall();
        logic [18:0] held;
        int i0;
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL steady_count: count=%0d required 1", fifo_count);
        end
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        held = exp_fetch;
        i0 = issued;
        repeat (5) begin
            tick();
            checks++;
            if (imem_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_rd: rd=%b required 0", imem_rd_en);
            end
        end
        checks++;
        if (fifo_count !== 3'd2 || issued != i0) begin
            errors++;
            $display("FAIL stall_capture: count=%0d issued=%0d required 2 and 0", fifo_count, issued - i0);
        end
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        tick();
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== held) begin
            errors++;
            $display("FAIL stall_resume: rd=%b addr=%h required 1 and %h", imem_rd_en, imem_addr, held);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({imem_rd_en, imem_addr, instr, instr_pc, instr_valid, fifo_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: rd=%b addr=%h instr=%h pc=%h v=%b cnt=%0d required all 0",
                     imem_rd_en, imem_addr, instr, instr_pc, instr_valid, fifo_count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_flush();
        test_redirect_with_pop();
        test_pc_wrap();
        test_fetch_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
